// File: rtl/or7_req_arbiter.sv
// Round-robin arbiter sharing one resource among 7 requesters.
// The grant is registered and one-hot, and it is held until done, a withdrawal or a hold timeout.
module or7_req_arbiter #(
   parameter int N_REQ    = 7,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic             grant_valid,
   output logic [2:0]       grant_id,
   output logic             busy,
   output logic             timeout
);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_GRANTED = 1'b1
   } state_e;

   localparam bit             HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

   state_e             state_q;
   logic [2:0]         ptr_q;
   logic [CNT_W-1:0]   hold_cnt_q;
   logic [N_REQ-1:0]   grant_q;
   logic [2:0]         grant_id_q;
   logic               grant_valid_q;
   logic               busy_q;
   logic               timeout_q;

   logic               any_req;
   logic               win_found;
   logic [2:0]         win_id;
   logic [2:0]         ptr_d;
   logic               rel_done;
   logic               rel_withdraw;
   logic               rel_limit;
   logic               release_now;

   assign any_req = |req;

   // Scan from ptr upward with wrap; iterating from the far end lets the nearest hit win.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         idx = (int'(ptr_q) + off) % N_REQ;
         if (req[idx]) begin
            win_found = 1'b1;
            win_id    = 3'(idx);
         end
      end
   end

   assign rel_done     = done;
   assign rel_withdraw = ~req[grant_id_q];
   assign rel_limit    = HOLD_EN && (hold_cnt_q == HOLD_LAST);
   assign release_now  = rel_done | rel_withdraw | rel_limit;
   assign ptr_d        = (grant_id_q == 3'(N_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         hold_cnt_q    <= '0;
         grant_q       <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req && win_found) begin
                  state_q       <= S_GRANTED;
                  grant_q       <= N_REQ'(1) << win_id;
                  grant_id_q    <= win_id;
                  grant_valid_q <= 1'b1;
                  busy_q        <= 1'b1;
                  hold_cnt_q    <= '0;
               end
            end
            S_GRANTED: begin
               if (release_now) begin
                  state_q       <= S_IDLE;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  busy_q        <= 1'b0;
                  ptr_q         <= ptr_d;
                  // A timeout is only reported when the limit alone forced the release.
                  timeout_q     <= rel_limit & ~rel_done & ~rel_withdraw;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q       <= S_IDLE;
               grant_q       <= '0;
               grant_valid_q <= 1'b0;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_or7_req_arbiter.sv
// Bench for or7_req_arbiter: a per-edge reference model feeds a scoreboard queue,
// a monitor compares DUT outputs, and directed phases check the named scenarios.
module tb_or7_req_arbiter;

   localparam int MAX_HOLD = 16;

   typedef struct {
      logic [6:0] grant;
      logic [2:0] grant_id;
      logic       grant_valid;
      logic       busy;
      logic       timeout;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] req;
   logic       done;
   logic [6:0] grant;
   logic       grant_valid;
   logic [2:0] grant_id;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   exp_t exp_q[$];

   // Reference model state: owner index (-1 when idle), pointer, cycles granted so far.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   int m_last  = 0;
   bit m_to    = 1'b0;

   or7_req_arbiter #(.N_REQ(7), .MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model step: what every output should look like right after this edge.
   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
         m_last  = 0;
         m_to    = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < 7; k++) begin
            int i;
            i = (m_ptr + k) % 7;
            if (m_owner < 0 && req[i]) begin
               m_owner = i;
               m_last  = i;
               m_held  = 1;
            end
         end
      end else begin
         bit lim;
         lim  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
         m_to = lim && !done && req[m_owner];
         if (done || !req[m_owner] || lim) begin
            m_ptr   = (m_owner + 1) % 7;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end
      e.grant       = (m_owner >= 0) ? 7'(1 << m_owner) : 7'd0;
      e.grant_id    = 3'(m_last);
      e.grant_valid = (m_owner >= 0);
      e.busy        = (m_owner >= 0);
      e.timeout     = m_to;
      exp_q.push_back(e);
   end

   // Monitor: compare the DUT against the oldest expectation shortly after each edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_empty: no expectation queued at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         check("sb_grant",       32'(grant),       32'(e.grant));
         check("sb_grant_id",    32'(grant_id),    32'(e.grant_id));
         check("sb_grant_valid", 32'(grant_valid), 32'(e.grant_valid));
         check("sb_busy",        32'(busy),        32'(e.busy));
         check("sb_timeout",     32'(timeout),     32'(e.timeout));
      end
   end

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      while (!busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      req   = 7'h7F;
      done  = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("rst_grant", 32'(grant), 32'd0);
         check("rst_busy",  32'(busy),  32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("first_grant",    32'(grant),    32'h01);
      check("first_grant_id", 32'(grant_id), 32'd0);

      for (int i = 0; i < 8; i++) begin
         wait_grant("rr_wait");
         check("rr_order", 32'(grant_id), 32'(i % 7));
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
         check("rr_idle_gap", 32'(busy), 32'd0);
      end

      do_reset();
      req = 7'b0100000;
      @(negedge clk);
      wait_grant("wrap_wait5");
      check("wrap_owner5", 32'(grant_id), 32'd5);
      req = '0;
      @(negedge clk);
      req = 7'b0001001;
      @(negedge clk);
      wait_grant("wrap_wait0");
      check("wrap_skip_to0", 32'(grant_id), 32'd0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      wait_grant("wrap_wait3");
      check("wrap_then3", 32'(grant_id), 32'd3);
      req = '0;

      do_reset();
      req = 7'h04;
      @(negedge clk);
      wait_grant("to_wait");
      cnt = 1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
      end
      check("to_hold_len", 32'(cnt),     32'(MAX_HOLD));
      check("to_pulse",    32'(timeout), 32'd1);
      @(negedge clk);
      check("to_pulse_end", 32'(timeout), 32'd0);
      wait_grant("to_regrant");
      check("to_regrant_id", 32'(grant_id), 32'd2);

      repeat (MAX_HOLD - 1) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("simul_drop",     32'(busy),    32'd0);
      check("simul_no_pulse", 32'(timeout), 32'd0);
      req = '0;

      do_reset();
      req = 7'h10;
      @(negedge clk);
      wait_grant("wd_wait");
      check("wd_owner4", 32'(grant_id), 32'd4);
      req = '0;
      @(negedge clk);
      check("wd_drop", 32'(grant), 32'd0);
      req = 7'h30;
      @(negedge clk);
      wait_grant("wd_ptr_wait");
      check("wd_ptr5", 32'(grant_id), 32'd5);
      req = '0;
      @(negedge clk);
      req = 7'h10;
      @(negedge clk);
      wait_grant("mr_wait");
      rst_n = 1'b0;
      @(negedge clk);
      check("mr_drop", 32'(grant), 32'd0);
      rst_n = 1'b1;
      req   = 7'h7F;
      @(negedge clk);
      wait_grant("mr_regrant");
      check("mr_ptr0", 32'(grant_id), 32'd0);

      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(99) != 0);
         if ($urandom_range(3) == 0) req[$urandom_range(6)] = ~req[$urandom_range(6)];
         if ($urandom_range(19) == 0) req = 7'($urandom);
         done = ($urandom_range(5) == 0);
         if (grant_valid) check("rand_onehot", 32'($countones(grant)), 32'd1);
      end

      rst_n = 1'b1;
      done  = 1'b0;
      req   = '0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/or7_req_arbiter.md
Name: or7_req_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource among 7 requesters.
- The "any request pending" term is the 7-input OR of req[6:0].
- The arbiter issues a registered one-hot grant and holds it until the owner releases it or a hold timeout fires.
- Sits between requesting units and the shared resource; downstream muxes select on grant_id.

Parameters:
- N_REQ, 7, number of requesters; fixed at 7 (the design supports only 7).
- MAX_HOLD, 16, maximum cycles one owner keeps the grant; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  7  request vector; bit i is held high while requester i wants the resource.
- done  input  1  owner release strobe; sampled only in GRANTED.
- grant  output  7  registered one-hot grant; all zero when idle.
- grant_valid  output  1  high while any grant bit is set.
- grant_id  output  3  binary index of the owner (0..6); holds its last value when idle.
- busy  output  1  high in GRANTED state.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset: at the clk edge with rst_n=0:
  - grant=0, grant_valid=0, grant_id=0, busy=0, timeout=0;
  - ptr=0, hold_cnt=0, state=IDLE.
- Reset has priority over everything. Reset mid-grant drops grant at that edge.
- States: IDLE, GRANTED. All outputs are registered.
- IDLE:
  - Stays in IDLE while req==0.
  - If req!=0 at an edge, go to GRANTED at that edge. Winner = first set bit scanning ptr, ptr+1, ... 6, 0, ... (mod 7 wrap).
  - grant/grant_id/grant_valid/busy update at that same edge, so latency is 1 cycle from req seen to grant visible.
  - hold_cnt is cleared to 0 on entry.
- GRANTED (owner = grant_id), release condition evaluated each edge:
  - R1: done=1.
  - R2: req[owner]=0 (requester withdrew).
  - R3: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- On release:
  - State goes to IDLE and grant goes to 0 at that edge.
  - ptr = owner+1, wrapping 6 to 0.
  - timeout=1 for exactly one cycle only if R3 is true and neither R1 nor R2 is.
- Without release: hold_cnt increments; the grant is unchanged.
- Other requesters' req changes during GRANTED are ignored; grant never switches directly between owners.
- Turnaround:
  - At least one IDLE cycle always separates consecutive grants.
  - Back-to-back requests from the same requester are served again only if no other requester is pending at the re-arbitration edge (round-robin fairness).
- Edge cases:
  - done asserted in IDLE is ignored.
  - done and req[owner] falling together count as one release; timeout=0.
  - MAX_HOLD=1: grant lasts exactly 1 cycle and timeout pulses at the release edge unless done or req drop.
  - Grant is never multi-hot; grant is never set for a bit whose req was 0 at the arbitration edge.

Test Plan:
- Reset and idle:
  - Hold rst_n=0 for 2 cycles with req=7'h7F, then release reset → grant=0, busy=0 during reset.
  - The edge after reset release gives grant=7'h01, grant_id=0.
- Round-robin order:
  - req=7'h7F held continuously; owner pulses done 1 cycle after each grant.
  - Required grant_id sequence: 0,1,2,3,4,5,6,0 with one idle cycle between each grant.
- Wrap and skip:
  - Last owner 5 (ptr=6); then req=7'b0001001 → grant_id=0, not 3.
  - Next arbitration with the same req → grant_id=3.
- Timeout (MAX_HOLD=16):
  - req=7'h04 held, done never asserted.
  - grant=7'h04 for exactly 16 cycles, then grant=0 with timeout=1 for 1 cycle; ptr=3.
  - Next grant to requester 2 follows after the idle cycle.
- Simultaneous release:
  - On the timeout edge (hold_cnt=15), assert done=1.
  - Grant drops and timeout stays 0.
- Withdrawal and mid-grant reset:
  - Owner 4 drops req[4] → grant=0 at the next edge, ptr=5.
  - Reassert req[4] and assert rst_n=0 during the grant → grant=0 at that edge, ptr=0.
